// File: rtl/fir_pkg.sv
// Shared types and fixed-point helpers for the transposed-form FIR filter.
package fir_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int RS_W           = 64;

    typedef logic signed [DEF_DATA_WIDTH-1:0] coef_t;

    typedef struct packed {
        logic signed [RS_W-1:0] data;
        logic                   sat;
    } rs_t;

    function automatic int acc_width(input int data_w, input int num_taps);
        return 2 * data_w + $clog2(num_taps);
    endfunction

    // Round half toward +inf, drop frac_w bits, then clip to a data_w-bit signed range.
    function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc,
                                      input int data_w, input int frac_w);
        logic signed [RS_W-1:0] one;
        logic signed [RS_W-1:0] rnd;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        rs_t                    res;
        one = {{(RS_W-1){1'b0}}, 1'b1};
        rnd = (acc + (one <<< (frac_w - 1))) >>> frac_w;
        hi  = (one <<< (data_w - 1)) - one;
        lo  = -(one <<< (data_w - 1));
        if (rnd > hi) begin
            res.data = hi;
            res.sat  = 1'b1;
        end else if (rnd < lo) begin
            res.data = lo;
            res.sat  = 1'b1;
        end else begin
            res.data = rnd;
            res.sat  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_tap.sv
// One transposed-form FIR stage: partial sum p <= x*h + p_in while enabled.
module fir_tap
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 35
) (
    input  logic                         clk,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic signed [DATA_WIDTH-1:0] h_i,
    input  logic signed [ACC_WIDTH-1:0]  p_i,
    output logic signed [ACC_WIDTH-1:0]  sum_o,
    output logic signed [ACC_WIDTH-1:0]  p_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    p_d;
    logic signed [ACC_WIDTH-1:0]    p_q;

    // Full-precision product, sign-extended into the accumulator width.
    assign prod  = (2*DATA_WIDTH)'(x_i) * (2*DATA_WIDTH)'(h_i);
    assign p_d   = ACC_WIDTH'(prod) + p_i;
    assign sum_o = p_d;
    assign p_o   = p_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/fir_systolic_pipe.sv
// N-tap transposed-form FIR: input register, runtime coefficient file, tap chain,
// and a rounded/saturated output register. Latency two cycles, one sample per clock.
module fir_systolic_pipe
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 14,
    parameter int NUM_TAPS   = 8,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, NUM_TAPS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    input  logic                          coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0]   coef_addr,
    input  logic signed [DATA_WIDTH-1:0]  coef_data,
    output logic                          out_valid,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    output logic                          out_sat
);

    localparam int              ADDR_W = $clog2(NUM_TAPS);
    localparam logic [ADDR_W:0] TAPS_L = (ADDR_W+1)'(NUM_TAPS);

    logic signed [DATA_WIDTH-1:0]      x_q;
    logic                              xv_q;
    logic signed [DATA_WIDTH-1:0]      coef_q [NUM_TAPS];
    logic                              out_valid_q;
    logic signed [DATA_WIDTH-1:0]      out_data_q;
    logic                              out_sat_q;

    logic signed [ACC_WIDTH-1:0]       p_chain [NUM_TAPS+1];
    logic signed [ACC_WIDTH-1:0]       tap_sum [NUM_TAPS];
    logic                              clr;
    rs_t                               rs;
    logic [RS_W-DATA_WIDTH-1:0]        rs_hi_unused;
    logic signed [DATA_WIDTH-1:0]      out_data_d;
    logic                              out_sat_d;

    assign clr               = reset | flush;
    assign p_chain[NUM_TAPS] = '0;

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        fir_tap #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_tap (
            .clk   (clk),
            .clr_i (clr),
            .en_i  (xv_q),
            .x_i   (x_q),
            .h_i   (coef_q[k]),
            .p_i   (p_chain[k+1]),
            .sum_o (tap_sum[k]),
            .p_o   (p_chain[k])
        );
    end

    // The output register captures the new p[0] directly from tap 0's adder.
    assign rs                          = round_sat(RS_W'(tap_sum[0]), DATA_WIDTH, FRAC_WIDTH);
    assign {rs_hi_unused, out_data_d}  = rs.data;
    assign out_sat_d                   = rs.sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= '0;
            xv_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            if (coef_we && ({1'b0, coef_addr} < TAPS_L)) begin
                coef_q[coef_addr] <= coef_data;
            end
            if (flush) begin
                x_q         <= '0;
                xv_q        <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                xv_q        <= in_valid;
                out_valid_q <= xv_q;
                if (in_valid) begin
                    x_q <= in_data;
                end
                if (xv_q) begin
                    out_data_q <= out_data_d;
                    out_sat_q  <= out_sat_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_systolic_pipe.sv
// Directed bench for fir_systolic_pipe (4 taps, Q2.14) plus a 5-tap instance for address range.
module tb_fir_systolic_pipe;
    import fir_pkg::*;

    logic clk;
    logic reset, flush, in_valid, coef_we;
    logic signed [15:0] in_data, coef_data;
    logic [1:0] coef_addr;
    logic out_valid, out_sat;
    logic signed [15:0] out_data;

    logic flush5, in_valid5, coef_we5;
    logic signed [15:0] in_data5, coef_data5;
    logic [2:0] coef_addr5;
    logic out_valid5, out_sat5;
    logic signed [15:0] out_data5;

    int checks = 0;
    int failures = 0;

    logic signed [15:0] obs_d[$];
    logic obs_s[$];
    logic signed [15:0] exp_d[$];
    logic exp_s[$];
    logic signed [15:0] obs5_d[$];

    fir_systolic_pipe #(.DATA_WIDTH(16), .FRAC_WIDTH(14), .NUM_TAPS(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat)
    );

    fir_systolic_pipe #(.DATA_WIDTH(16), .FRAC_WIDTH(14), .NUM_TAPS(5)) dut5 (
        .clk(clk), .reset(reset), .flush(flush5), .in_valid(in_valid5), .in_data(in_data5),
        .coef_we(coef_we5), .coef_addr(coef_addr5), .coef_data(coef_data5),
        .out_valid(out_valid5), .out_data(out_data5), .out_sat(out_sat5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) begin
            obs_d.push_back(out_data);
            obs_s.push_back(out_sat);
        end
        if (out_valid5) obs5_d.push_back(out_data5);
    end

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x);
        in_valid = 1'b1;
        in_data  = 16'(x);
        tick();
    endtask

    task automatic send5(input int x);
        in_valid5 = 1'b1;
        in_data5  = 16'(x);
        tick();
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        in_valid5 = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr(input int addr, input coef_t data);
        in_valid  = 1'b0;
        coef_we   = 1'b1;
        coef_addr = 2'(addr);
        coef_data = data;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic wr5(input int addr, input coef_t data);
        in_valid5  = 1'b0;
        coef_we5   = 1'b1;
        coef_addr5 = 3'(addr);
        coef_data5 = data;
        tick();
        coef_we5 = 1'b0;
    endtask

    task automatic set_h(input int h0, input int h1, input int h2, input int h3);
        wr(0, 16'(h0));
        wr(1, 16'(h1));
        wr(2, 16'(h2));
        wr(3, 16'(h3));
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic expect_out(input int d, input logic s);
        exp_d.push_back(16'(d));
        exp_s.push_back(s);
    endtask

    task automatic compare_out(input string tag);
        check_val({tag, "_count"}, obs_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            check_val($sformatf("%s_d%0d", tag, i), obs_d[i], exp_d[i]);
            check_val($sformatf("%s_s%0d", tag, i), obs_s[i], exp_s[i]);
        end
        obs_d.delete();
        obs_s.delete();
        exp_d.delete();
        exp_s.delete();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        flush5 = 1'b0; in_valid5 = 1'b0; in_data5 = '0;
        coef_we5 = 1'b0; coef_addr5 = '0; coef_data5 = '0;
        repeat (3) tick();
        reset = 1'b0;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_sat", out_sat, 0);

        // Impulse response and two-cycle latency
        set_h(8192, 4096, -4096, 2048);
        do_flush();
        send(16384);
        check_val("lat_t1_valid", out_valid, 0);
        send(0);
        check_val("lat_t2_valid", out_valid, 1);
        check_val("lat_t2_data", out_data, 8192);
        send(0); send(0); send(0);
        idle(3);
        expect_out(8192, 0); expect_out(4096, 0); expect_out(-4096, 0);
        expect_out(2048, 0); expect_out(0, 0);
        compare_out("impulse");

        // Saturation, positive then negative
        set_h(16384, 16384, 16384, 16384);
        do_flush();
        repeat (6) send(32767);
        idle(3);
        expect_out(32767, 0);
        repeat (5) expect_out(32767, 1);
        compare_out("sat_pos");
        do_flush();
        repeat (6) send(-32768);
        idle(3);
        expect_out(-32768, 0);
        repeat (5) expect_out(-32768, 1);
        compare_out("sat_neg");

        // Round half toward +inf with h0 = 0.5
        set_h(8192, 0, 0, 0);
        do_flush();
        send(3); send(-3); send(1); send(-1);
        idle(3);
        expect_out(2, 0); expect_out(-1, 0); expect_out(1, 0); expect_out(0, 0);
        compare_out("round");

        // Gaps in in_valid stall the chain without inserting zeros
        set_h(8192, 4096, -4096, 2048);
        do_flush();
        send(16384); idle(3);
        send(0); idle(3);
        send(0); idle(3);
        send(0); idle(3);
        check_val("hold_valid", out_valid, 0);
        check_val("hold_data", out_data, 2048);
        expect_out(8192, 0); expect_out(4096, 0); expect_out(-4096, 0); expect_out(2048, 0);
        compare_out("stall");

        // Flush after the second output drops the in-flight result and the flush-cycle sample
        send(16384); send(0); send(0);
        flush = 1'b1;
        send(7777);
        flush = 1'b0;
        check_val("flush_cancel", out_valid, 0);
        idle(1);
        send(16384); send(0); send(0); send(0);
        idle(4);
        expect_out(8192, 0); expect_out(4096, 0);
        expect_out(8192, 0); expect_out(4096, 0); expect_out(-4096, 0); expect_out(2048, 0);
        compare_out("flush");

        // Coefficient written in the same cycle as the sample is used by that sample
        wr(1, 0); wr(2, 0); wr(3, 0);
        do_flush();
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'sd16384;
        in_valid = 1'b1; in_data = 16'sd100;
        tick();
        coef_we = 1'b0;
        idle(3);
        expect_out(100, 0);
        compare_out("coef_same_cycle");

        // 5-tap instance: addresses 5..7 are out of range and must be ignored
        wr5(0, 16'sd16384);
        wr5(4, 16'sd4096);
        wr5(5, 16'sd12345);
        wr5(6, -16'sd7000);
        wr5(7, 16'sd3000);
        send5(16384); send5(0); send5(0); send5(0); send5(0);
        idle(3);
        check_val("oor_count", obs5_d.size(), 5);
        for (int i = 0; i < 5 && i < obs5_d.size(); i++) begin
            check_val($sformatf("oor_d%0d", i), obs5_d[i], (i == 0) ? 16384 : ((i == 4) ? 4096 : 0));
        end

        // Reset mid-stream with saturated output showing and samples in flight
        set_h(16384, 16384, 16384, 16384);
        do_flush();
        send(32767); send(32767); send(32767);
        check_val("pre_rst_sat", out_sat, 1);
        reset = 1'b1;
        send(32767);
        reset = 1'b0;
        in_valid = 1'b0;
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_data", out_data, 0);
        check_val("mid_rst_sat", out_sat, 0);
        obs_d.delete();
        obs_s.delete();
        idle(4);
        compare_out("no_stale");
        send(16384); send(0); send(0); send(0);
        idle(3);
        repeat (4) expect_out(0, 0);
        compare_out("rst_coef_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
